// File: rtl/video_timing_gen.sv
// Runtime-reprogrammable raster timing generator: pixel/line counters, sync,
// active-draw and frame strobes, with new timing taken only at frame boundaries.
module video_timing_gen #(
  parameter int H_W          = 11,
  parameter int V_W          = 10,
  parameter int DEF_H_ACTIVE = 1280,
  parameter int DEF_H_FP     = 110,
  parameter int DEF_H_SYNC   = 40,
  parameter int DEF_H_BP     = 220,
  parameter int DEF_V_ACTIVE = 720,
  parameter int DEF_V_FP     = 5,
  parameter int DEF_V_SYNC   = 5,
  parameter int DEF_V_BP     = 20,
  parameter int H_SYNC_POL   = 1,
  parameter int V_SYNC_POL   = 1,
  parameter int FPS          = 60
) (
  input  logic             pixel_clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [4*H_W-1:0] cfg_h,
  input  logic [4*V_W-1:0] cfg_v,
  output logic             cfg_err,
  output logic [H_W-1:0]   h_count,
  output logic [V_W-1:0]   v_count,
  output logic             h_sync,
  output logic             v_sync,
  output logic             active_draw,
  output logic             line_end,
  output logic             new_frame,
  output logic [5:0]       frame_count
);

  localparam int HS = H_W + 2;
  localparam int VS = V_W + 2;

  localparam logic [4*H_W-1:0] DEF_H = {H_W'(DEF_H_ACTIVE), H_W'(DEF_H_FP),
                                        H_W'(DEF_H_SYNC), H_W'(DEF_H_BP)};
  localparam logic [4*V_W-1:0] DEF_V = {V_W'(DEF_V_ACTIVE), V_W'(DEF_V_FP),
                                        V_W'(DEF_V_SYNC), V_W'(DEF_V_BP)};

  logic [4*H_W-1:0] act_h, pend_h;
  logic [4*V_W-1:0] act_v, pend_v;
  logic             pend;

  logic [H_W-1:0] h_active, h_fp, h_sw, h_bp;
  logic [V_W-1:0] v_active, v_fp, v_sw, v_bp;
  logic [HS-1:0]  h_total, hs_start, hs_end, h_ext;
  logic [VS-1:0]  v_total, vs_start, vs_end, v_ext;
  logic           h_last, v_last, h_sync_on, v_sync_on;

  assign {h_active, h_fp, h_sw, h_bp} = act_h;
  assign {v_active, v_fp, v_sw, v_bp} = act_v;

  assign h_total  = HS'(h_active) + HS'(h_fp) + HS'(h_sw) + HS'(h_bp);
  assign v_total  = VS'(v_active) + VS'(v_fp) + VS'(v_sw) + VS'(v_bp);
  assign hs_start = HS'(h_active) + HS'(h_fp);
  assign hs_end   = hs_start + HS'(h_sw);
  assign vs_start = VS'(v_active) + VS'(v_fp);
  assign vs_end   = vs_start + VS'(v_sw);
  assign h_ext    = HS'(h_count);
  assign v_ext    = VS'(v_count);

  assign h_last    = (h_ext == h_total - HS'(1));
  assign v_last    = (v_ext == v_total - VS'(1));
  assign h_sync_on = (h_ext >= hs_start) && (h_ext < hs_end);
  assign v_sync_on = (v_ext >= vs_start) && (v_ext < vs_end);

  // Decode is purely combinational so it lines up with the counters; holding
  // the counters with enable low therefore holds every level output too.
  assign active_draw = (h_count < h_active) && (v_count < v_active);
  assign h_sync      = (H_SYNC_POL != 0) ? h_sync_on : ~h_sync_on;
  assign v_sync      = (V_SYNC_POL != 0) ? v_sync_on : ~v_sync_on;
  assign line_end    = enable && h_last;
  assign new_frame   = line_end && v_last;
  assign cfg_ready   = ~pend;

  // Pending timing is sanity-checked before it may replace the live timing.
  logic [H_W-1:0] p_h_active, p_h_fp, p_h_sw, p_h_bp;
  logic [V_W-1:0] p_v_active, p_v_fp, p_v_sw, p_v_bp;
  logic [HS-1:0]  p_h_total;
  logic [VS-1:0]  p_v_total;
  logic           pend_ok;

  assign {p_h_active, p_h_fp, p_h_sw, p_h_bp} = pend_h;
  assign {p_v_active, p_v_fp, p_v_sw, p_v_bp} = pend_v;
  assign p_h_total = HS'(p_h_active) + HS'(p_h_fp) + HS'(p_h_sw) + HS'(p_h_bp);
  assign p_v_total = VS'(p_v_active) + VS'(p_v_fp) + VS'(p_v_sw) + VS'(p_v_bp);
  assign pend_ok   = (p_h_total <= (HS'(1) << H_W)) && (p_v_total <= (VS'(1) << V_W)) &&
                     (p_h_active != '0) && (p_h_sw != '0) &&
                     (p_v_active != '0) && (p_v_sw != '0);

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_count     <= '0;
      v_count     <= '0;
      frame_count <= '0;
    end else if (enable) begin
      if (h_last) begin
        h_count <= '0;
        if (v_last) begin
          v_count     <= '0;
          frame_count <= (frame_count == 6'(FPS - 1)) ? 6'd0 : frame_count + 6'd1;
        end else begin
          v_count <= v_count + 1'b1;
        end
      end else begin
        h_count <= h_count + 1'b1;
      end
    end
  end

  // Apply and accept can never coincide: apply needs pend set, accept needs it clear.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      act_h   <= DEF_H;
      act_v   <= DEF_V;
      pend_h  <= '0;
      pend_v  <= '0;
      pend    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (new_frame && pend) begin
        pend <= 1'b0;
        if (pend_ok) begin
          act_h <= pend_h;
          act_v <= pend_v;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (cfg_valid && !pend) begin
        pend_h <= cfg_h;
        pend_v <= cfg_v;
        pend   <= 1'b1;
      end
    end
  end

endmodule
